// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the execute stage.
//   - IR field bit positions
//   - opcode encodings
//   - FSM state encoding
//   - flag bit indices within the {sign, zero, overflow, carry} vector
package risc_pkg;

    localparam int OPER_HI  = 31;
    localparam int OPER_LO  = 27;
    localparam int RDST_HI  = 26;
    localparam int RDST_LO  = 22;
    localparam int RSRC1_HI = 21;
    localparam int RSRC1_LO = 17;
    localparam int IMM_BIT  = 16;
    localparam int RSRC2_HI = 15;
    localparam int RSRC2_LO = 11;
    localparam int ISRC_HI  = 15;
    localparam int ISRC_LO  = 0;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    typedef enum logic {IDLE, MUL_BUSY} state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_S = 3;

endpackage

// File: rtl/risc_exec_if.sv
// risc_exec_if: instruction handshake and retirement status bundle.
//   instr_valid/instr_ready/instr : IR handshake (master drives valid+instr)
//   done/illegal                  : one-cycle retirement pulses
//   flags                         : registered {sign, zero, overflow, carry}
interface risc_exec_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        done;
    logic        illegal;
    logic [3:0]  flags;

    modport master (output instr_valid, instr,
                    input  instr_ready, done, illegal, flags);
    modport slave  (input  instr_valid, instr,
                    output instr_ready, done, illegal, flags);
endinterface

// File: rtl/risc_seq_mul.sv
// risc_seq_mul: iterative shift-add unsigned multiplier, one bit per cycle.
//   start   : latch a/b and begin (ignored while busy)
//   busy    : iteration in progress
//   valid   : high during the final iteration cycle; product is the final
//             value in that cycle, so the owner can write back on that edge
//   product : running accumulator plus this cycle's partial product
module risc_seq_mul #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  valid,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc, mcand, acc_nxt;
    logic [DATA_W-1:0]   mplier;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign valid   = busy && (count == CNT_W'(DATA_W - 1));
    assign product = acc_nxt;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (valid)
                busy <= 1'b0;
        end
    end
endmodule

// File: rtl/risc_exec_unit.sv
// risc_exec_unit: registered execute stage with GPR file, SGPR and flags.
//   clk, sys_rst : clock, asynchronous active-high reset
//   bus          : instruction handshake / retirement status (slave side)
//   dbg_addr     : debug GPR read index
//   dbg_data     : GPR[dbg_addr], 0 when out of range (combinational)
//   dbg_sgpr     : SGPR contents
// Single-cycle ops write back on the accept edge; MUL writes back on the
// last multiplier iteration edge. done/illegal follow the writeback edge.
module risc_exec_unit
    import risc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_GPR = 32
) (
    input  logic              clk,
    input  logic              sys_rst,
    risc_exec_if.slave        bus,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] dbg_sgpr
);
    localparam int M = DATA_W - 1;

    state_e              state, state_nxt;
    logic [DATA_W-1:0]   gpr [NUM_GPR];
    logic [DATA_W-1:0]   sgpr;
    logic [3:0]          flags_q;
    logic                done_q, illegal_q;
    logic [4:0]          mul_rdst;

    logic [4:0]          oper, rdst, rsrc1, rsrc2;
    logic                imm_mode, accept;
    logic [DATA_W-1:0]   imm, rs1_val, rs2_val, op_a, op_b, src_u, res;
    logic                c, v, legal, is_mul;
    logic [3:0]          alu_flags, mul_flags;

    logic                mul_busy, mul_valid;
    logic [2*DATA_W-1:0] product;

    logic                single, wr_en;
    logic [4:0]          wr_idx;
    logic [DATA_W-1:0]   wr_data;

    assign oper     = bus.instr[OPER_HI:OPER_LO];
    assign rdst     = bus.instr[RDST_HI:RDST_LO];
    assign rsrc1    = bus.instr[RSRC1_HI:RSRC1_LO];
    assign rsrc2    = bus.instr[RSRC2_HI:RSRC2_LO];
    assign imm_mode = bus.instr[IMM_BIT];
    assign imm      = DATA_W'(bus.instr[ISRC_HI:ISRC_LO]);
    assign accept   = bus.instr_valid && bus.instr_ready;

    // Register reads; indices beyond the implemented file read as zero.
    always_comb begin
        rs1_val  = '0;
        rs2_val  = '0;
        dbg_data = '0;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (rsrc1 == 5'(i))    rs1_val  = gpr[i];
            if (rsrc2 == 5'(i))    rs2_val  = gpr[i];
            if (dbg_addr == 5'(i)) dbg_data = gpr[i];
        end
    end

    assign op_a  = rs1_val;
    assign op_b  = imm_mode ? imm : rs2_val;
    assign src_u = imm_mode ? imm : rs1_val;   // unary source for mov/not

    always_comb begin
        res    = '0;
        c      = 1'b0;
        v      = 1'b0;
        legal  = 1'b1;
        is_mul = 1'b0;
        case (oper)
            OP_MOVSGPR: res = sgpr;
            OP_MOV:     res = src_u;
            OP_ADD: begin
                {c, res} = {1'b0, op_a} + {1'b0, op_b};
                v = (op_a[M] == op_b[M]) && (res[M] != op_a[M]);
            end
            OP_SUB: begin
                res = op_a - op_b;
                c   = op_a < op_b;
                v   = (op_a[M] != op_b[M]) && (res[M] != op_a[M]);
            end
            OP_MUL:  is_mul = 1'b1;
            OP_OR:   res = op_a | op_b;
            OP_AND:  res = op_a & op_b;
            OP_XOR:  res = op_a ^ op_b;
            OP_XNOR: res = ~(op_a ^ op_b);
            OP_NAND: res = ~(op_a & op_b);
            OP_NOR:  res = ~(op_a | op_b);
            OP_NOT:  res = ~src_u;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_S] = res[M];
        alu_flags[FLAG_Z] = (res == '0);
        alu_flags[FLAG_V] = v;
        alu_flags[FLAG_C] = c;
        mul_flags         = '0;
        mul_flags[FLAG_S] = product[2*DATA_W-1];
        mul_flags[FLAG_Z] = (product == '0);
    end

    risc_seq_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .sys_rst (sys_rst),
        .start   (accept && is_mul),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .valid   (mul_valid),
        .product (product)
    );

    // Accept only happens in IDLE and MUL retirement only in MUL_BUSY, so the
    // two writeback sources never collide.
    assign single  = accept && legal && !is_mul;
    assign wr_en   = single || mul_valid;
    assign wr_idx  = mul_valid ? mul_rdst : rdst;
    assign wr_data = mul_valid ? product[DATA_W-1:0] : res;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.instr_ready = !mul_busy;
                if (accept && is_mul)
                    state_nxt = MUL_BUSY;
            end
            MUL_BUSY: begin
                if (mul_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_GPR; i++)
                gpr[i] <= '0;
            sgpr      <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            mul_rdst  <= '0;
        end else begin
            done_q    <= (accept && !is_mul) || mul_valid;
            illegal_q <= accept && !legal;
            if (wr_en)
                for (int i = 0; i < NUM_GPR; i++)
                    if (wr_idx == 5'(i))
                        gpr[i] <= wr_data;
            if (single)
                flags_q <= alu_flags;
            if (mul_valid) begin
                flags_q <= mul_flags;
                sgpr    <= product[2*DATA_W-1:DATA_W];
            end
            if (accept && is_mul)
                mul_rdst <= rdst;
        end
    end

    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.flags   = flags_q;
    assign dbg_sgpr    = sgpr;
endmodule

// File: tb/tb_risc_exec_unit.sv
module tb_risc_exec_unit;
    localparam int DATA_W = 16;

    localparam logic [4:0] MOVSGPR = 5'd0, MOV = 5'd1, ADD = 5'd2, SUB = 5'd3, MUL = 5'd4;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic [4:0]        dbg_addr, dbg_addr8;
    logic [DATA_W-1:0] dbg_data, dbg_sgpr, dbg_data8, dbg_sgpr8;

    int checks = 0;
    int errors = 0;

    risc_exec_if bus ();
    risc_exec_if bus8 ();

    // Second instance with a reduced register file sees the same stream.
    assign bus8.instr_valid = bus.instr_valid;
    assign bus8.instr       = bus.instr;

    risc_exec_unit #(.DATA_W(DATA_W), .NUM_GPR(32)) u_dut (
        .clk(clk), .sys_rst(sys_rst), .bus(bus),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_sgpr(dbg_sgpr)
    );

    risc_exec_unit #(.DATA_W(DATA_W), .NUM_GPR(8)) u_dut8 (
        .clk(clk), .sys_rst(sys_rst), .bus(bus8),
        .dbg_addr(dbg_addr8), .dbg_data(dbg_data8), .dbg_sgpr(dbg_sgpr8)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          lat;
        int          rdylow;
        logic        ill;
        logic [3:0]  flg;
        int          addr;
        logic [15:0] val;
        logic        chk_sgpr;
        logic [15:0] sgpr;
    } exp_t;

    exp_t sb[$];
    int   next_id = 0;

    task automatic chk(input string tag, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s#%0d got=%h exp=%h", tag, id, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic im,
                                        input logic [15:0] lo);
        return {op, rd, rs1, im, lo};
    endfunction

    function automatic logic [15:0] rs2f(input logic [4:0] r);
        return {r, 11'b0};
    endfunction

    // Push the expectation, drive the IR, wait (bounded) for done, then pop
    // and compare. Leaves instr_valid low so a following call accepts on the
    // very next edge.
    task automatic issue(input logic [31:0] ins, input int lat, input int rdylow,
                         input logic ill, input logic [3:0] flg, input int addr,
                         input logic [15:0] val, input logic cs, input logic [15:0] sg);
        exp_t e, g;
        int   n, rl;
        e = '{id: next_id, lat: lat, rdylow: rdylow, ill: ill, flg: flg, addr: addr,
              val: val, chk_sgpr: cs, sgpr: sg};
        next_id++;
        sb.push_back(e);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        chk("ready_before", e.id, 32'(bus.instr_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        n  = 1;
        rl = 0;
        forever begin
            if (!bus.instr_ready) rl++;
            if (bus.done || n >= 40) break;
            @(posedge clk);
            #1;
            n++;
        end
        g = sb.pop_front();
        chk("done", g.id, 32'(bus.done), 32'd1);
        chk("latency", g.id, 32'(n), 32'(g.lat));
        chk("ready_low", g.id, 32'(rl), 32'(g.rdylow));
        chk("illegal", g.id, 32'(bus.illegal), 32'(g.ill));
        chk("flags", g.id, 32'(bus.flags), 32'(g.flg));
        dbg_addr = 5'(g.addr);
        #1;
        chk("gpr", g.id, 32'(dbg_data), 32'(g.val));
        if (g.chk_sgpr)
            chk("sgpr", g.id, 32'(dbg_sgpr), 32'(g.sgpr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        sys_rst         = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        dbg_addr        = '0;
        dbg_addr8       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        chk("rst_ready", 0, 32'(bus.instr_ready), 32'd1);
        chk("rst_done", 0, 32'(bus.done), 32'd0);
        chk("rst_illegal", 0, 32'(bus.illegal), 32'd0);
        chk("rst_flags", 0, 32'(bus.flags), 32'd0);
        chk("rst_sgpr", 0, 32'(dbg_sgpr), 32'd0);
        chk("rst_r0", 0, 32'(dbg_data), 32'd0);

        // 1: signed overflow on add, back-to-back
        issue(enc(MOV, 5'd1, 5'd0, 1'b1, 16'h7FFF), 1, 0, 1'b0, 4'b0000, 1, 16'h7FFF, 1'b0, 16'h0);
        issue(enc(ADD, 5'd2, 5'd1, 1'b1, 16'h0001), 1, 0, 1'b0, 4'b1010, 2, 16'h8000, 1'b0, 16'h0);
        // 2: unsigned wrap, carry + zero
        issue(enc(MOV, 5'd3, 5'd0, 1'b1, 16'hFFFF), 1, 0, 1'b0, 4'b1000, 3, 16'hFFFF, 1'b0, 16'h0);
        issue(enc(ADD, 5'd4, 5'd3, 1'b1, 16'h0001), 1, 0, 1'b0, 4'b0101, 4, 16'h0000, 1'b0, 16'h0);
        // 3: sub borrow
        issue(enc(MOV, 5'd5, 5'd0, 1'b1, 16'h0003), 1, 0, 1'b0, 4'b0000, 5, 16'h0003, 1'b0, 16'h0);
        issue(enc(MOV, 5'd6, 5'd0, 1'b1, 16'h0005), 1, 0, 1'b0, 4'b0000, 6, 16'h0005, 1'b0, 16'h0);
        issue(enc(SUB, 5'd7, 5'd5, 1'b0, rs2f(5'd6)), 1, 0, 1'b0, 4'b1001, 7, 16'hFFFE, 1'b0, 16'h0);
        // 4: multiply 0x1234 * 0x5678 = 0x06260060
        issue(enc(MOV, 5'd1, 5'd0, 1'b1, 16'h1234), 1, 0, 1'b0, 4'b0000, 1, 16'h1234, 1'b0, 16'h0);
        issue(enc(MOV, 5'd2, 5'd0, 1'b1, 16'h5678), 1, 0, 1'b0, 4'b0000, 2, 16'h5678, 1'b0, 16'h0);
        issue(enc(MUL, 5'd8, 5'd1, 1'b0, rs2f(5'd2)), 17, 16, 1'b0, 4'b0000, 8, 16'h0060, 1'b1, 16'h0626);
        issue(enc(MOVSGPR, 5'd9, 5'd0, 1'b0, 16'h0), 1, 0, 1'b0, 4'b0000, 9, 16'h0626, 1'b0, 16'h0);

        // Reduced file: index 8 write dropped, out-of-range reads zero
        dbg_addr8 = 5'd8;  #1; chk("gpr8_r8", 0, 32'(dbg_data8), 32'd0);
        dbg_addr8 = 5'd1;  #1; chk("gpr8_r1", 0, 32'(dbg_data8), 32'h1234);
        dbg_addr8 = 5'd31; #1; chk("gpr8_r31", 0, 32'(dbg_data8), 32'd0);
        chk("sgpr8", 0, 32'(dbg_sgpr8), 32'h0626);

        // 5: reset aborts an in-flight multiply
        @(negedge clk);
        bus.instr       = enc(MUL, 5'd10, 5'd1, 1'b0, rs2f(5'd2));
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        chk("mul_busy", 0, 32'(bus.instr_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        sys_rst = 1'b1;
        #1;
        chk("abort_ready", 0, 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        sys_rst = 1'b0;
        pulses  = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        chk("abort_no_done", 0, 32'(pulses), 32'd0);
        chk("abort_ready2", 0, 32'(bus.instr_ready), 32'd1);
        chk("abort_flags", 0, 32'(bus.flags), 32'd0);
        chk("abort_sgpr", 0, 32'(dbg_sgpr), 32'd0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk("abort_gpr", a, 32'(dbg_data), 32'd0);
        end

        // 6: illegal opcode leaves state untouched
        issue(enc(MOV, 5'd1, 5'd0, 1'b1, 16'h1234), 1, 0, 1'b0, 4'b0000, 1, 16'h1234, 1'b0, 16'h0);
        issue(enc(MOV, 5'd3, 5'd0, 1'b1, 16'hFFFF), 1, 0, 1'b0, 4'b1000, 3, 16'hFFFF, 1'b0, 16'h0);
        issue(enc(5'h1F, 5'd1, 5'd0, 1'b1, 16'hAAAA), 1, 0, 1'b1, 4'b1000, 1, 16'h1234, 1'b1, 16'h0);
        @(posedge clk);
        #1;
        chk("ill_done_once", 0, 32'(bus.done), 32'd0);
        chk("ill_pulse_once", 0, 32'(bus.illegal), 32'd0);
        chk("ill_flags_hold", 0, 32'(bus.flags), 32'b1000);
        dbg_addr8 = 5'd31; #1; chk("dbg8_oor", 0, 32'(dbg_data8), 32'd0);
        dbg_addr8 = 5'd1;  #1; chk("dbg8_r1", 0, 32'(dbg_data8), 32'h1234);
        chk("sb_empty", 0, 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/risc_exec_unit.md
Name: risc_exec_unit

Overview:
Registered execute stage for the 32-bit-IR RISC core. It holds a parametrised GPR file, the SGPR and a flag register. Instructions arrive over a valid/ready handshake. ALU and logical ops retire in one cycle; MUL runs on an iterative shift-add multiplier controlled by a small FSM. Flags (sign, zero, carry, overflow) are clocked state updated on retirement, and carry now also covers SUB borrow.

Parameters:
DATA_W, 16, GPR/SGPR width; isrc (16 bits) is zero-extended or truncated to DATA_W
NUM_GPR, 32, implemented registers (1..32); rdst/rsrc indices >= NUM_GPR read 0 and writes are dropped

Ports:
clk  in  1  core clock
sys_rst  in  1  asynchronous, active-high reset
instr_valid  in  1  IR presented
instr_ready  out  1  unit can accept (state IDLE)
instr  in  32  IR: oper[31:27] rdst[26:22] rsrc1[21:17] imm_mode[16] rsrc2[15:11] isrc[15:0]
done  out  1  one-cycle pulse: an instruction retired
illegal  out  1  one-cycle pulse: unknown opcode retired
flags  out  4  {sign, zero, overflow, carry}, registered
dbg_addr  in  5  debug GPR read index
dbg_data  out  DATA_W  combinational GPR[dbg_addr] (0 if out of range)
dbg_sgpr  out  DATA_W  SGPR contents

Behaviour:
- Reset (async, any state): all GPRs = 0, SGPR = 0, flags = 0, done = 0, illegal = 0, FSM = IDLE, so instr_ready = 1 in the first cycle after release.
- Accept occurs on a clock edge where instr_valid && instr_ready. instr may change freely when not accepted.
- Opcodes: movsgpr=0, mov=1, add=2, sub=3, mul=4, or=5, and=6, xor=7, xnor=8, nand=9, nor=10, not=11. imm_mode selects isrc instead of GPR[rsrc2]; for mov/not it selects isrc instead of GPR[rsrc1].
- Single-cycle ops: at the accept edge, write GPR[rdst] and flags. done is high in the following cycle. FSM stays IDLE, so back-to-back accept every cycle is allowed. Source operands are read before the write (rdst == rsrc is legal).
- MUL:
  - Accept edge: latch both operands, count = 0, FSM → MUL_BUSY, instr_ready = 0.
  - Each MUL_BUSY edge performs one shift-add iteration.
  - On the DATA_W-th iteration edge: GPR[rdst] = product[DATA_W-1:0], SGPR = product[2*DATA_W-1:DATA_W], flags update, FSM → IDLE.
  - done is high in the next cycle. Total: done is asserted DATA_W+1 cycles after the accept edge. instr_valid is ignored while busy.
- Flags are evaluated on the result and written only on retirement:
  - sign = result MSB; for MUL, product MSB.
  - zero = result == 0; for MUL, the full 2*DATA_W product == 0.
  - carry = bit DATA_W of the unsigned sum for add; borrow (op1 < op2, unsigned) for sub; 0 otherwise.
  - overflow = signed overflow for add/sub; 0 otherwise.
  - movsgpr: sign/zero from the moved value.
- Unknown opcode (12..31): no GPR/SGPR/flag write; illegal and done pulse together in the next cycle.
- Reset during MUL_BUSY aborts the multiply with no writeback; all state takes reset values.
- dbg_data and dbg_sgpr show pre-writeback values until the retiring edge.

Decomposition:
- Package risc_pkg: opcode constants, IR field bit positions, FSM state encoding (IDLE, MUL_BUSY), flag bit indices.
- One sub-module, risc_seq_mul. Parameter DATA_W; ports clk, sys_rst, start, a, b, busy, valid, product. It holds the iteration counter and accumulator; the top owns the handshake and writeback.

Test Plan:
1. mov imm R1=0x7FFF; add imm R2=R1+1 → R2=0x8000, flags sign=1 zero=0 ov=1 carry=0; done 1 cycle after each accept; back-to-back accepts with instr_ready constantly 1.
2. mov imm R3=0xFFFF; add imm R4=R3+1 → R4=0x0000, zero=1 carry=1 ov=0 sign=0.
3. mov imm R5=3, R6=5; sub reg R7=R5−R6 → R7=0xFFFE, carry(borrow)=1 sign=1 ov=0.
4. R1=0x1234, R2=0x5678; mul reg R8 → instr_ready low 16 cycles, done 17 cycles after accept. R8=0x0060, SGPR=0x0626, zero=0 sign=0. Then movsgpr R9 → R9=0x0626.
5. Start mul; assert sys_rst after 5 iterations → all GPRs, SGPR and flags = 0; instr_ready=1 after release; no done pulse.
6. Opcode 5'b11111 with rdst=R1 holding 0x1234 → illegal and done pulse once; R1 and flags unchanged. dbg_addr=31 with NUM_GPR=8 → dbg_data=0.
